// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, parity modes, default frame
// geometry and a constant-evaluable clog2.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: d -> meta -> q.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority voting, false-start rejection,
// run-time parity and framing/parity/overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_enb,
  input  logic                 rdy_clr,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] SAMP_A  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP_B  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] VOTE_AT = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, idx_n;
  logic                 armed, armed_n;
  logic                 rx_s;
  logic                 samp0, samp1, vote, at_vote;
  logic [DATA_BITS-1:0] shift;
  logic                 par_en_q, par_odd_q, par_err_l, frm_err_l;
  logic                 start_frame, enter_data, deliver;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign vote    = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign at_vote = (cnt == VOTE_AT);

  // State and bit-timing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      armed   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= idx_n;
      armed   <= armed_n;
    end
  end

  // Next-state, counter advance and datapath strobes; everything holds off-tick.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = bit_idx;
    armed_n     = armed;
    start_frame = 1'b0;
    enter_data  = 1'b0;
    deliver     = 1'b0;
    if (rx_enb) begin
      cnt_n = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          cnt_n = '0;
          if (!armed) begin
            if (rx_s) armed_n = 1'b1;
          end else if (!rx_s) begin
            state_n     = START;
            cnt_n       = CNT_W'(1);
            start_frame = 1'b1;
          end
        end
        START: begin
          if (at_vote && vote) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == LAST) begin
            state_n    = DATA;
            idx_n      = '0;
            enter_data = 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            if (bit_idx == LAST_DATA) begin
              idx_n   = '0;
              state_n = par_en_q ? PARITY : STOP;
            end else begin
              idx_n = bit_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (cnt == LAST) state_n = STOP;
        end
        STOP: begin
          // Deliver at the last stop-bit vote so the next start edge can be
          // caught during the remaining half bit.
          if (at_vote && bit_idx == LAST_STOP) begin
            deliver = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
            armed_n = !(frm_err_l || !vote);
          end else if (cnt == LAST) begin
            idx_n = bit_idx + IDX_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Vote sampling, data shift, error latches and registered host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= PARITY_EVEN;
      par_err_l  <= 1'b0;
      frm_err_l  <= 1'b0;
      rdy        <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_enb && cnt == SAMP_A) samp0 <= rx_s;
      if (rx_enb && cnt == SAMP_B) samp1 <= rx_s;
      if (start_frame) begin
        shift     <= '0;
        par_err_l <= 1'b0;
        frm_err_l <= 1'b0;
      end
      if (enter_data) begin
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
      end
      if (rx_enb && at_vote) begin
        case (state)
          DATA: begin
            for (int unsigned i = 0; i < DATA_BITS; i++)
              if (bit_idx == IDX_W'(i)) shift[i] <= vote;
          end
          PARITY: par_err_l <= (vote != ((^shift) ^ par_odd_q));
          STOP: if (!vote) frm_err_l <= 1'b1;
          default: ;
        endcase
      end
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (deliver) begin
        data_out   <= shift;
        rdy        <= 1'b1;
        parity_err <= par_err_l;
        frame_err  <= frm_err_l | ~vote;
        if (rdy && !rdy_clr) overrun <= 1'b1;
      end
    end
  end

endmodule
